// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and line constants for the uart transmitter
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } uart_tx_state_e;

    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - latched baud divisor and bit-period tick counter
module uart_baud_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 tick_o
);

    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] cnt_q;

    assign tick_o = (cnt_q == (div_q - DIV_WIDTH'(1)));

    // The divisor is captured only at frame start so mid-frame changes are ignored.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q <= DIV_WIDTH'(1);
            cnt_q <= '0;
        end else if (start_i) begin
            div_q <= (div_i == '0) ? DIV_WIDTH'(1) : div_i;
            cnt_q <= '0;
        end else if (tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - fifo-draining uart transmitter; UART_TX_PARITY_EN adds a parity bit
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [DIV_WIDTH-1:0]  div_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_rd_o,
    output logic                  tx_o,
    output logic                  busy_o
);

    localparam int BIT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 2;

    uart_tx_state_e        state_q, state_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic                  par_q;
    logic                  tx_q, tx_d;
    logic                  busy_q;
    logic                  rd;
    logic                  pop_ok;
    logic                  tick;

    assign pop_ok    = en_i & ~fifo_empty_i & ~rst_i;
    assign fifo_rd_o = rd;
    assign tx_o      = tx_q;
    assign busy_o    = busy_q;

    uart_baud_gen #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_baud (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start_i(rd),
        .div_i  (div_i),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        rd      = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (pop_ok) begin
                    rd      = 1'b1;
                    state_d = TX_START;
                    sh_d    = fifo_data_i;
                    bit_d   = '0;
                end
            end
            TX_START: begin
                if (tick) begin
                    state_d = TX_DATA;
                    bit_d   = '0;
                end
            end
            TX_DATA: begin
                if (tick) begin
                    sh_d = sh_q >> 1;
                    if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = TX_PARITY;
`else
                        state_d = TX_STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            TX_PARITY: begin
                if (tick) begin
                    state_d = TX_STOP;
                    bit_d   = '0;
                end
            end
            TX_STOP: begin
                if (tick) begin
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        bit_d = '0;
                        // Chain straight into the next frame without an idle cycle.
                        if (pop_ok) begin
                            rd      = 1'b1;
                            state_d = TX_START;
                            sh_d    = fifo_data_i;
                        end else begin
                            state_d = TX_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase

        // The line level is registered from the next state so tx_o lines up with state_q.
        case (state_d)
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = sh_d[0];
            TX_PARITY: tx_d = par_q;
            default:   tx_d = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= TX_IDLE;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tx_q    <= UART_IDLE_LEVEL;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            busy_q  <= (state_d != TX_IDLE);
            if (rd) begin
                par_q <= (^fifo_data_i) ^ 1'(PARITY_ODD);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;

    localparam int PODD = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [15:0] div = 16'd4;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_rd;
    logic        tx;
    logic        busy;

    logic [7:0] fmem [0:15];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         bad_pops = 0;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_data  = fmem[rd_ptr[3:0]];

    always @(posedge clk) begin
        if (fifo_rd) rd_ptr <= rd_ptr + 1;
    end

    always @(negedge clk) begin
        if (fifo_rd && fifo_empty) bad_pops++;
    end

    uart_tx #(
        .DATA_WIDTH(8),
        .DIV_WIDTH (16),
        .STOP_BITS (1),
        .PARITY_ODD(PODD)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .div_i       (div),
        .fifo_empty_i(fifo_empty),
        .fifo_data_i (fifo_data),
        .fifo_rd_o   (fifo_rd),
        .tx_o        (tx),
        .busy_o      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        fmem[wr_ptr % 16] = d;
        wr_ptr++;
    endtask

    // Returns at the negedge of the first start-bit cycle when a pop is seen.
    task automatic wait_rd(input string tag, input int limit);
        logic found;
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            #1;
            if (fifo_rd) found = 1'b1;
            else @(negedge clk);
        end
        check(tag, found, 1'b1);
        @(negedge clk);
    endtask

    // Samples one value per bit period; also counts unstable cycles, busy cycles and the first pop.
    task automatic capture(input int nbits, input int d, output logic [31:0] bits,
                           output int unstable, output int busy_cnt, output int rd_idx);
        bits = '0;
        unstable = 0;
        busy_cnt = 0;
        rd_idx = -1;
        for (int i = 0; i < nbits * d; i++) begin
            if (i % d == 0) bits[i / d] = tx;
            else if (tx !== bits[i / d]) unstable++;
            if (busy) busy_cnt++;
            if (fifo_rd && rd_idx < 0) rd_idx = i;
            @(negedge clk);
        end
    endtask

    logic [31:0] bits;
    int unstable, busy_cnt, rd_idx, p0, cnt_rd, cnt_low, cnt_busy;

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_rd", fifo_rd, 1'b0);
        rst = 1'b0;

        // empty fifo, enabled
        cnt_rd = 0; cnt_low = 0; cnt_busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fifo_rd) cnt_rd++;
            if (!tx) cnt_low++;
            if (busy) cnt_busy++;
        end
        check("empty_rd", cnt_rd, 0);
        check("empty_tx_low", cnt_low, 0);
        check("empty_busy", cnt_busy, 0);

`ifdef UART_TX_PARITY_EN
        // parity frame, div 1, data 0x07
        div = 16'd1;
        p0 = rd_ptr;
        push(8'h07);
        wait_rd("par_pop", 20);
        capture(11, 1, bits, unstable, busy_cnt, rd_idx);
        check("par_frame", bits, (PODD != 0) ? 32'h40E : 32'h60E);
        check("par_busy", busy_cnt, 11);
        check("par_idle_tx", tx, 1'b1);
        check("par_pops", rd_ptr - p0, 1);
`else
        // 0x55 at div 4
        div = 16'd4;
        p0 = rd_ptr;
        push(8'h55);
        wait_rd("t2_pop", 20);
        capture(10, 4, bits, unstable, busy_cnt, rd_idx);
        check("t2_frame", bits, 32'h2AA);
        check("t2_stable", unstable, 0);
        check("t2_busy", busy_cnt, 40);
        check("t2_end_busy", busy, 1'b0);
        check("t2_end_tx", tx, 1'b1);
        check("t2_pops", rd_ptr - p0, 1);

        // back-to-back 0xA5, 0x3C at div 2
        div = 16'd2;
        p0 = rd_ptr;
        push(8'hA5);
        push(8'h3C);
        wait_rd("t3_pop", 20);
        capture(20, 2, bits, unstable, busy_cnt, rd_idx);
        check("t3_frames", bits, 32'h9E34A);
        check("t3_stable", unstable, 0);
        check("t3_busy", busy_cnt, 40);
        check("t3_rd_idx", rd_idx, 19);
        check("t3_pops", rd_ptr - p0, 2);
        check("t3_end_busy", busy, 1'b0);

        // div 0, en dropped mid-frame with fifo non-empty
        div = 16'd0;
        p0 = rd_ptr;
        push(8'h00);
        push(8'h81);
        wait_rd("t6_pop", 20);
        en = 1'b0;
        capture(10, 1, bits, unstable, busy_cnt, rd_idx);
        check("t6_frame", bits, 32'h200);
        check("t6_busy", busy_cnt, 10);
        repeat (20) @(negedge clk);
        check("t6_held_pops", rd_ptr - p0, 1);
        check("t6_held_busy", busy, 1'b0);
        en = 1'b1;
        wait_rd("t6_pop2", 20);
        capture(10, 1, bits, unstable, busy_cnt, rd_idx);
        check("t6_frame2", bits, 32'h302);
        check("t6_pops", rd_ptr - p0, 2);
`endif

        // reset during data bit 3 of 0xFF
        div = 16'd4;
        p0 = rd_ptr;
        push(8'hFF);
        push(8'h11);
        wait_rd("t5_pop", 20);
        en = 1'b0;
        repeat (16) @(negedge clk);
        check("t5_bit3", tx, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_tx", tx, 1'b1);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_rd", fifo_rd, 1'b0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("t5_pops", rd_ptr - p0, 1);
        check("t5_idle_busy", busy, 1'b0);
`ifndef UART_TX_PARITY_EN
        en = 1'b1;
        wait_rd("t5_pop2", 20);
        capture(10, 4, bits, unstable, busy_cnt, rd_idx);
        check("t5_frame2", bits, 32'h222);
        check("t5_pops2", rd_ptr - p0, 2);
`endif

        check("no_empty_pop", bad_pops, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
